// File: rtl/expr_pkg.sv
// Shared encodings for the expression scheduler: token kinds, operator codes,
// FSM states and the operator precedence helper.
package expr_pkg;

   typedef enum logic [1:0] {
      TK_OPND = 2'd0,
      TK_OP   = 2'd1,
      TK_END  = 2'd2,
      TK_RSVD = 2'd3
   } tok_kind_e;

   localparam logic [7:0] OP_ADD = 8'h2B;
   localparam logic [7:0] OP_SUB = 8'h2D;
   localparam logic [7:0] OP_MUL = 8'h2A;
   localparam logic [7:0] OP_DIV = 8'h2F;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_CMP,
      S_PUSH_OP,
      S_REDUCE,
      S_DRAIN,
      S_DONE,
      S_ERR
   } state_e;

   // 0 marks an illegal operator code.
   function automatic logic [1:0] prec(input logic [7:0] code);
      case (code)
         OP_MUL, OP_DIV: return 2'd2;
         OP_ADD, OP_SUB: return 2'd1;
         default:        return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/sched_timeout.sv
// Down-counting watchdog: load arms it, clr parks it at zero, expired while zero.
module sched_timeout #(
   parameter int TW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load,
   input  logic          clr,
   input  logic [TW-1:0] load_val,
   output logic          expired
);

   logic [TW-1:0] cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (clr) begin
         cnt <= '0;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign expired = (cnt == '0);

endmodule

// File: rtl/expr_sched.sv
// Shunting-yard token scheduler: drives the external operand/operator stacks
// and fires the calculation unit once per reduction.
//
// state   | meaning
// IDLE    | no expression open, ready for the first token
// FETCH   | accepting tokens; operands pushed straight through
// CMP     | compare pending operator with operator stack top
// PUSH_OP | push pending operator
// REDUCE  | fire calc_start, wait for calc_complete (watchdogged)
// DRAIN   | end seen, reduce until operator stack is empty
// DONE    | capture result from operand stack top, clear counters
// ERR     | sticky error, held until reset
module expr_sched
   import expr_pkg::*;
#(
   parameter int W       = 8,
   parameter int DEPTH   = 16,
   parameter int TIMEOUT = 255
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         tok_valid,
   output logic         tok_ready,
   input  logic [1:0]   tok_kind,
   input  logic [W-1:0] tok_data,
   output logic         opnd_push,
   output logic [W-1:0] opnd_Din,
   output logic         op_push,
   output logic [W-1:0] op_Din,
   input  logic [W-1:0] op_top,
   input  logic [W-1:0] opnd_top,
   output logic         calc_start,
   input  logic         calc_complete,
   output logic         done,
   output logic [W-1:0] result,
   output logic         err
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_TWO  = CW'(2);
   // calc_complete is honoured up to TIMEOUT-1 cycles after calc_start; err shows at TIMEOUT.
   localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT - 2);

   state_e        state, state_nxt, ret_state;
   tok_kind_e     kind;
   logic [CW-1:0] opnd_cnt, op_cnt;
   logic [W-1:0]  pend_op, result_r;
   logic          busy, done_r;
   logic          accept, red_finish, done_ok, tmo_expired;

   assign kind = tok_kind_e'(tok_kind);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_FETCH: begin
            if (tok_valid) begin
               case (kind)
                  TK_OPND: state_nxt = (opnd_cnt == CNT_MAX) ? S_ERR : S_FETCH;
                  TK_OP:   state_nxt = (prec(8'(tok_data)) == 2'd0) ? S_ERR : S_CMP;
                  TK_END:  state_nxt = (state == S_IDLE) ? S_DONE : S_DRAIN;
                  default: state_nxt = S_ERR;
               endcase
            end
         end
         S_CMP: begin
            if (op_cnt != '0 && prec(8'(op_top)) >= prec(8'(pend_op))) state_nxt = S_REDUCE;
            else                                                        state_nxt = S_PUSH_OP;
         end
         S_PUSH_OP: state_nxt = (op_cnt == CNT_MAX) ? S_ERR : S_FETCH;
         S_REDUCE: begin
            if (!busy) begin
               if (opnd_cnt < CNT_TWO) state_nxt = S_ERR;
            end else if (calc_complete) begin
               state_nxt = ret_state;
            end else if (tmo_expired) begin
               state_nxt = S_ERR;
            end
         end
         S_DRAIN: state_nxt = (op_cnt != '0) ? S_REDUCE : S_DONE;
         S_DONE:  state_nxt = (opnd_cnt > 1) ? S_ERR : S_IDLE;
         default: state_nxt = S_ERR;
      endcase
   end

   // Outputs are gated by reset so everything reads 0 the moment reset falls.
   always_comb begin
      tok_ready  = reset && (state == S_IDLE || state == S_FETCH);
      accept     = tok_valid && tok_ready;
      opnd_push  = accept && kind == TK_OPND && opnd_cnt != CNT_MAX;
      opnd_Din   = opnd_push ? tok_data : '0;
      op_push    = reset && state == S_PUSH_OP && op_cnt != CNT_MAX;
      op_Din     = op_push ? pend_op : '0;
      calc_start = reset && state == S_REDUCE && !busy && opnd_cnt >= CNT_TWO;
      red_finish = state == S_REDUCE && busy && calc_complete;
      done_ok    = state == S_DONE && opnd_cnt <= 1;
      err        = state == S_ERR;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pend_op   <= '0;
         ret_state <= S_CMP;
         busy      <= 1'b0;
         opnd_cnt  <= '0;
         op_cnt    <= '0;
         done_r    <= 1'b0;
         result_r  <= '0;
      end else begin
         if (accept && kind == TK_OP) pend_op <= tok_data;
         if (state_nxt == S_REDUCE && state != S_REDUCE)
            ret_state <= (state == S_DRAIN) ? S_DRAIN : S_CMP;
         busy   <= (state_nxt == S_REDUCE) && (calc_start || busy);
         done_r <= done_ok;
         if (done_ok) begin
            result_r <= (opnd_cnt == '0) ? '0 : opnd_top;
            opnd_cnt <= '0;
            op_cnt   <= '0;
         end else begin
            if (opnd_push) opnd_cnt <= opnd_cnt + 1'b1;
            if (op_push)   op_cnt   <= op_cnt + 1'b1;
            // Calc unit pops two operands and pushes one back: net -1.
            if (red_finish) begin
               opnd_cnt <= opnd_cnt - 1'b1;
               op_cnt   <= op_cnt - 1'b1;
            end
         end
      end
   end

   assign done   = done_r;
   assign result = result_r;

   sched_timeout #(.TW(TW)) u_tmo (
      .clk      (clk),
      .reset    (reset),
      .load     (calc_start),
      .clr      (red_finish),
      .load_val (TMO_LOAD),
      .expired  (tmo_expired)
   );

endmodule

// File: tb/tb_expr_sched.sv
// Scoreboard bench for expr_sched with behavioural operand/operator stacks
// and a calculation unit model.
module tb_expr_sched;
   import expr_pkg::*;

   localparam int W       = 8;
   localparam int DEPTH   = 16;
   localparam int TIMEOUT = 255;
   localparam int CALC_LAT = 3;

   logic         clk, reset, tok_valid, tok_ready;
   logic [1:0]   tok_kind;
   logic [W-1:0] tok_data, opnd_Din, op_Din, op_top, opnd_top, result;
   logic         opnd_push, op_push, calc_start, calc_complete, done, err;

   expr_sched #(.W(W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .tok_valid(tok_valid), .tok_ready(tok_ready),
      .tok_kind(tok_kind), .tok_data(tok_data), .opnd_push(opnd_push),
      .opnd_Din(opnd_Din), .op_push(op_push), .op_Din(op_Din), .op_top(op_top),
      .opnd_top(opnd_top), .calc_start(calc_start), .calc_complete(calc_complete),
      .done(done), .result(result), .err(err)
   );

   typedef struct { bit is_err; logic [W-1:0] val; } exp_t;
   exp_t sb_q[$];

   int checks = 0, errors = 0;
   int cyc = 0;
   int n_opnd = 0, n_op = 0, n_calc = 0, n_done = 0, n_err = 0, n_multi = 0;
   int calc_cyc = 0, err_cyc = 0;
   bit withhold = 0, cc_real = 0;
   int late_req = 0, late_ack = 0;
   logic [W-1:0] opnd_stk[DEPTH], op_stk[DEPTH];
   int opnd_sp = 0, op_sp = 0;
   logic [W-1:0] applied_ops[$];

   assign op_top   = (op_sp > 0)   ? op_stk[op_sp-1]     : '0;
   assign opnd_top = (opnd_sp > 0) ? opnd_stk[opnd_sp-1] : '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   function automatic logic [W-1:0] apply(input logic [W-1:0] a, input logic [W-1:0] o,
                                          input logic [W-1:0] b);
      case (o)
         8'h2B:   return a + b;
         8'h2D:   return a - b;
         8'h2A:   return a * b;
         8'h2F:   return (b != 0) ? a / b : '0;
         default: return '0;
      endcase
   endfunction

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // External stacks: sampled at the rising edge, pre-edge DUT outputs.
   initial forever begin
      @(posedge clk);
      if (!reset) begin
         opnd_sp = 0;
         op_sp   = 0;
      end else begin
         if (done) begin
            opnd_sp = 0;
            op_sp   = 0;
         end
         if (opnd_push && opnd_sp < DEPTH) begin
            opnd_stk[opnd_sp] = opnd_Din;
            opnd_sp++;
         end
         if (op_push && op_sp < DEPTH) begin
            op_stk[op_sp] = op_Din;
            op_sp++;
         end
         if (calc_complete && cc_real && opnd_sp >= 2 && op_sp >= 1) begin
            logic [W-1:0] a, b, o;
            b = opnd_stk[opnd_sp-1];
            a = opnd_stk[opnd_sp-2];
            o = op_stk[op_sp-1];
            applied_ops.push_back(o);
            opnd_sp--;
            op_sp--;
            opnd_stk[opnd_sp-1] = apply(a, o, b);
         end
      end
   end

   // Calculation unit: completes CALC_LAT cycles after calc_start unless withheld.
   initial begin
      int remaining;
      bit st;
      remaining = 0;
      calc_complete = 0;
      forever begin
         @(posedge clk);
         st = calc_start && reset;
         #1;
         calc_complete = 0;
         cc_real = 0;
         if (!reset) remaining = 0;
         if (st && !withhold) remaining = CALC_LAT;
         if (remaining > 0) begin
            remaining--;
            if (remaining == 0) begin
               calc_complete = 1;
               cc_real = 1;
            end
         end
         if (late_req != late_ack) begin
            late_ack++;
            calc_complete = 1;
         end
      end
   end

   // Monitor: pops the scoreboard on done pulses and err rising edges.
   initial begin
      bit prev_err;
      exp_t e;
      prev_err = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            if (opnd_push) n_opnd++;
            if (op_push) n_op++;
            if (calc_start) begin
               n_calc++;
               calc_cyc = cyc;
            end
            if (int'(opnd_push) + int'(op_push) + int'(calc_start) > 1) n_multi++;
            if (done) begin
               chk("sb_done_expected", 32'(sb_q.size() > 0), 1);
               if (sb_q.size() > 0) begin
                  e = sb_q.pop_front();
                  chk("done_kind", 32'(e.is_err), 0);
                  chk("result", 32'(result), 32'(e.val));
               end
               n_done++;
            end
            if (err && !prev_err) begin
               chk("sb_err_expected", 32'(sb_q.size() > 0), 1);
               if (sb_q.size() > 0) begin
                  e = sb_q.pop_front();
                  chk("err_kind", 32'(e.is_err), 1);
               end
               err_cyc = cyc;
               n_err++;
            end
            prev_err = err;
         end else begin
            prev_err = 0;
         end
      end
   end

   task automatic expect_result(input logic [W-1:0] v);
      exp_t e;
      e.is_err = 0;
      e.val = v;
      sb_q.push_back(e);
   endtask

   task automatic expect_err();
      exp_t e;
      e.is_err = 1;
      e.val = '0;
      sb_q.push_back(e);
   endtask

   task automatic send(input logic [1:0] k, input logic [7:0] d);
      int n;
      n = 0;
      @(posedge clk);
      #1;
      tok_valid = 1;
      tok_kind = k;
      tok_data = d;
      @(negedge clk);
      while (!tok_ready && n < 400) begin
         n++;
         @(negedge clk);
      end
      chk("tok_accept", 32'(tok_ready), 1);
      @(posedge clk);
      #1;
      tok_valid = 0;
   endtask

   task automatic wait_done(input int base);
      int n;
      n = 0;
      while (n_done <= base && n < 2000) begin
         n++;
         @(negedge clk);
      end
      chk("done_seen", 32'(n_done > base), 1);
   endtask

   task automatic wait_err(input int base);
      int n;
      n = 0;
      while (n_err <= base && n < 2000) begin
         n++;
         @(negedge clk);
      end
      chk("err_seen", 32'(n_err > base), 1);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      reset = 0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1;
   endtask

   initial begin
      int b_calc, b_done, b_err, b_opnd, b_ops, b_str, n;
      reset = 0;
      tok_valid = 0;
      tok_kind = 0;
      tok_data = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", {tok_ready, opnd_push, op_push, calc_start, done, err,
                            result, opnd_Din, op_Din}, 0);
      @(posedge clk);
      #1;
      reset = 1;
      @(negedge clk);
      chk("idle_ready", 32'(tok_ready), 1);

      // 2 + 3 * 4 = 14, '*' reduced first
      b_calc = n_calc; b_done = n_done; b_ops = applied_ops.size();
      expect_result(8'd14);
      send(TK_OPND, 8'd2); send(TK_OP, 8'h2B); send(TK_OPND, 8'd3);
      send(TK_OP, 8'h2A); send(TK_OPND, 8'd4); send(TK_END, 8'd0);
      wait_done(b_done);
      chk("t1_calc_count", 32'(n_calc - b_calc), 2);
      chk("t1_first_op", 32'((applied_ops.size() > b_ops) ? applied_ops[b_ops] : 8'h00), 32'h2A);

      // empty expression: end token straight from IDLE
      b_done = n_done;
      expect_result(8'd0);
      send(TK_END, 8'd0);
      wait_done(b_done);

      // 8 - 3 - 1 = 4, left-associative
      b_calc = n_calc; b_done = n_done;
      expect_result(8'd4);
      send(TK_OPND, 8'd8); send(TK_OP, 8'h2D); send(TK_OPND, 8'd3);
      send(TK_OP, 8'h2D); send(TK_OPND, 8'd1);
      chk("t2_reduce_on_second_minus", 32'(n_calc - b_calc), 1);
      send(TK_END, 8'd0);
      wait_done(b_done);
      chk("t2_calc_count", 32'(n_calc - b_calc), 2);

      // '+' 3 end: too few operands at reduction
      do_reset();
      b_err = n_err;
      expect_err();
      send(TK_OP, 8'h2B); send(TK_OPND, 8'd3); send(TK_END, 8'd0);
      wait_err(b_err);
      b_str = n_opnd + n_op + n_calc;
      repeat (10) @(negedge clk);
      chk("t3_no_strobes", 32'(n_opnd + n_op + n_calc - b_str), 0);
      chk("t3_ready_low", 32'(tok_ready), 0);
      chk("t3_err_sticky", 32'(err), 1);

      // operand overflow
      do_reset();
      b_opnd = n_opnd; b_err = n_err;
      for (int i = 0; i < DEPTH; i++) send(TK_OPND, 8'(i + 1));
      chk("t4_err_before_full", 32'(err), 0);
      expect_err();
      send(TK_OPND, 8'hEE);
      wait_err(b_err);
      chk("t4_push_count", 32'(n_opnd - b_opnd), DEPTH);

      // watchdog: calc_complete never returns
      do_reset();
      withhold = 1;
      b_err = n_err; b_calc = n_calc;
      expect_err();
      send(TK_OPND, 8'd2); send(TK_OP, 8'h2B); send(TK_OPND, 8'd3); send(TK_END, 8'd0);
      wait_err(b_err);
      chk("t5_calc_started", 32'(n_calc - b_calc), 1);
      chk("t5_timeout_cycles", 32'(err_cyc - calc_cyc), TIMEOUT);

      // reset in the middle of a reduction
      do_reset();
      b_calc = n_calc;
      send(TK_OPND, 8'd2); send(TK_OP, 8'h2B); send(TK_OPND, 8'd3); send(TK_END, 8'd0);
      n = 0;
      while (n_calc == b_calc && n < 100) begin
         n++;
         @(negedge clk);
      end
      chk("t6_calc_started", 32'(n_calc - b_calc), 1);
      repeat (2) @(posedge clk);
      #1;
      reset = 0;
      #1;
      chk("t6_outputs_cleared", {tok_ready, opnd_push, op_push, calc_start, done, err,
                                 result, opnd_Din, op_Din}, 0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1;
      withhold = 0;
      b_done = n_done;
      late_req++;
      repeat (3) @(negedge clk);
      chk("t6_late_complete_ignored", {30'd0, err, tok_ready}, 32'd1);
      chk("t6_no_spurious_done", 32'(n_done - b_done), 0);
      expect_result(8'd30);
      send(TK_OPND, 8'd5); send(TK_OP, 8'h2A); send(TK_OPND, 8'd6); send(TK_END, 8'd0);
      wait_done(b_done);

      repeat (3) @(negedge clk);
      chk("sb_drained", 32'(sb_q.size()), 0);
      chk("one_strobe_per_cycle", 32'(n_multi), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1, "bench timeout");
   end

endmodule
